memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-read-latency main memory between the CPU
//  (fetch and load/store, driven by the controller) and the display engine.
//  The display engine requests a burst of sequential reads. The arbiter
//  generates the burst addresses itself and interleaves them round-robin
//  with CPU accesses, so neither side can starve the other.
// PARAMETERS
//  ADDRESS_WIDTH  16  memory address width; burst addresses wrap modulo 2^ADDRESS_WIDTH
//  DATA_WIDTH     16  memory word width
//  BURST_WIDTH     8  width of burst length and index; max burst 2^BURST_WIDTH-1
// PORTS
//  clock                  in   1   rising-edge clock
//  reset                  in   1   synchronous, active-low
//  cpu_request            in   1   CPU access pending; hold with fields stable until granted
//  cpu_write_enable       in   1   1=write, 0=read
//  cpu_address            in   AW  CPU word address
//  cpu_write_data         in   DW  CPU write data
//  cpu_grant              out  1   combinational; access issued to memory this cycle
//  cpu_read_valid         out  1   registered; cpu_read_data valid (1 cycle after read grant)
//  cpu_read_data          out  DW  memory_read_data passthrough
//  display_request        in   1   one-cycle start pulse for a read burst
//  display_base_address   in   AW  burst start address, sampled on start
//  display_burst_length   in   BW  number of words, sampled on start
//  display_busy           out  1   registered; burst accepted and not yet complete
//  display_read_valid     out  1   registered; one display word returned this cycle
//  display_read_index     out  BW  registered; word offset of returned word (0..L-1)
//  display_read_data      out  DW  memory_read_data passthrough
//  display_done           out  1   registered; 1-cycle pulse with the last word's valid
//  memory_address         out  AW  to RAM
//  memory_write_data      out  DW  to RAM; equals cpu_write_data
//  memory_write_enable    out  1   to RAM; asserted only on a CPU write grant
//  memory_read_data       in   DW  from RAM, valid the cycle after the address
// BEHAVIOUR
//  - Reset (reset==0 at clock edge): burst FSM returns to IDLE; display_busy,
//    cpu_read_valid, display_read_valid and display_done clear to 0;
//    display_read_index clears to 0; last_owner is set to DISPLAY so the
//    first contested grant goes to the CPU. A reset mid-burst aborts the
//    burst without a display_done pulse. A read issued in the reset cycle
//    returns no valid.
//  - Burst FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//    IDLE: display_request with length L>0 latches base and L, clears the
//      issue count, and moves to ISSUE. L==0 is ignored and the FSM stays IDLE.
//    ISSUE: the display is eligible. Each display grant reads base+count and
//      increments count. The grant of word L-1 moves the FSM to DRAIN.
//    DRAIN: the display is not eligible. The next cycle returns the last word,
//      asserts display_done and moves the FSM to IDLE.
//    display_busy=1 in ISSUE and DRAIN. display_request while busy is ignored.
//  - Arbitration each cycle, eligible = {cpu_request, FSM==ISSUE}:
//    only one side eligible -> grant it (back-to-back grants allowed, full rate);
//    both eligible -> grant the side that is not last_owner;
//    last_owner updates on every grant; no grant -> memory_write_enable=0.
//  - Memory drive: memory_address = cpu_address on a CPU grant, otherwise
//    base+count (mod 2^AW).
//  - Read return: the granted owner and read-vs-write are registered 1 cycle.
//    cpu_read_valid=1 the cycle after a CPU read grant; a CPU write produces
//    no valid. display_read_valid/display_read_index appear the cycle after
//    each display grant. Exactly L display valids per burst, with indices
//    0..L-1 in order.
//  - Throughput: one memory access per cycle. A contended burst of L words
//    completes in 2L cycles; an uncontended burst completes in L+1 cycles
//    from the start.
// TESTING
//  - Reset then CPU read at 0x0010, display idle -> cpu_grant same cycle;
//    cpu_read_valid next cycle with RAM[0x0010].
//  - Burst base 0x0100, L=4, no CPU requests -> grants on 4 consecutive cycles;
//    valids with indices 0..3 carrying RAM[0x100..0x103]; display_done with
//    index 3; busy falls after.
//  - Burst L=3 plus CPU requesting continuously -> grant order CPU,D,CPU,D,CPU,D;
//    CPU writes land in RAM; no CPU read_valid for writes.
//  - Burst base 0xFFFE, L=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
//  - Request with L=0, then request while busy -> both ignored (busy stays as
//    before; no extra valids).
//  - Reset asserted after 2 of 5 burst words -> busy=0, no done, no further
//    valids; a new burst then runs normally.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the CPU controller, the display engine, the main RAM and the arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface memory_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned BURST_WIDTH   = 8
);
   logic                     cpu_request;
   logic                     cpu_write_enable;
   logic [ADDRESS_WIDTH-1:0] cpu_address;
   logic [DATA_WIDTH-1:0]    cpu_write_data;
   logic                     cpu_grant;
   logic                     cpu_read_valid;
   logic [DATA_WIDTH-1:0]    cpu_read_data;

   logic                     display_request;
   logic [ADDRESS_WIDTH-1:0] display_base_address;
   logic [BURST_WIDTH-1:0]   display_burst_length;
   logic                     display_busy;
   logic                     display_read_valid;
   logic [BURST_WIDTH-1:0]   display_read_index;
   logic [DATA_WIDTH-1:0]    display_read_data;
   logic                     display_done;

   logic [ADDRESS_WIDTH-1:0] memory_address;
   logic [DATA_WIDTH-1:0]    memory_write_data;
   logic                     memory_write_enable;
   logic [DATA_WIDTH-1:0]    memory_read_data;

   modport slave (
      input  cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
      output cpu_grant, cpu_read_valid, cpu_read_data,
      input  display_request, display_base_address, display_burst_length,
      output display_busy, display_read_valid, display_read_index, display_read_data,
      output display_done,
      output memory_address, memory_write_data, memory_write_enable,
      input  memory_read_data
   );

   modport master (
      output cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
      input  cpu_grant, cpu_read_valid, cpu_read_data,
      output display_request, display_base_address, display_burst_length,
      input  display_busy, display_read_valid, display_read_index, display_read_data,
      input  display_done,
      input  memory_address, memory_write_data, memory_write_enable,
      output memory_read_data
   );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency RAM between CPU accesses
// and self-addressed display read bursts.
module memory_arbiter #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned BURST_WIDTH   = 8
) (
   input  logic             clock,
   input  logic             reset,
   memory_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [BURST_WIDTH-1:0]   length_q, length_d;
   logic [BURST_WIDTH-1:0]   count_q, count_d;
   logic                     last_display_q, last_display_d;
   logic                     display_busy_q, display_busy_d;
   logic                     cpu_read_valid_q, cpu_read_valid_d;
   logic                     display_read_valid_q, display_read_valid_d;
   logic [BURST_WIDTH-1:0]   display_read_index_q, display_read_index_d;
   logic                     display_done_q, display_done_d;

   logic display_eligible;
   logic cpu_grant;
   logic display_grant;
   logic burst_last;

   // Contested cycles go to whichever side did not own the previous grant.
   always_comb begin
      display_eligible = (state_q == StIssue);
      cpu_grant        = bus.cpu_request && (!display_eligible || last_display_q);
      display_grant    = display_eligible && !cpu_grant;
      burst_last       = (count_q == (length_q - BURST_WIDTH'(1)));
   end

   assign bus.cpu_grant           = cpu_grant;
   assign bus.memory_address      = cpu_grant ? bus.cpu_address
                                              : base_q + ADDRESS_WIDTH'(count_q);
   assign bus.memory_write_data   = bus.cpu_write_data;
   assign bus.memory_write_enable = cpu_grant && bus.cpu_write_enable;

   assign bus.cpu_read_valid      = cpu_read_valid_q;
   assign bus.cpu_read_data       = bus.memory_read_data;
   assign bus.display_busy        = display_busy_q;
   assign bus.display_read_valid  = display_read_valid_q;
   assign bus.display_read_index  = display_read_index_q;
   assign bus.display_read_data   = bus.memory_read_data;
   assign bus.display_done        = display_done_q;

   always_comb begin
      state_d              = state_q;
      base_d               = base_q;
      length_d             = length_q;
      count_d              = count_q;
      last_display_d       = last_display_q;
      cpu_read_valid_d     = cpu_grant && !bus.cpu_write_enable;
      display_read_valid_d = display_grant;
      display_read_index_d = display_grant ? count_q : display_read_index_q;
      display_done_d       = 1'b0;

      if (cpu_grant) begin
         last_display_d = 1'b0;
      end else if (display_grant) begin
         last_display_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.display_request && (bus.display_burst_length != '0)) begin
               base_d   = bus.display_base_address;
               length_d = bus.display_burst_length;
               count_d  = '0;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            if (display_grant) begin
               count_d = count_q + BURST_WIDTH'(1);
               if (burst_last) begin
                  state_d        = StDrain;
                  display_done_d = 1'b1;
               end
            end
         end
         StDrain: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      display_busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q              <= StIdle;
         base_q               <= '0;
         length_q             <= '0;
         count_q              <= '0;
         last_display_q       <= 1'b1;
         display_busy_q       <= 1'b0;
         cpu_read_valid_q     <= 1'b0;
         display_read_valid_q <= 1'b0;
         display_read_index_q <= '0;
         display_done_q       <= 1'b0;
      end else begin
         state_q              <= state_d;
         base_q               <= base_d;
         length_q             <= length_d;
         count_q              <= count_d;
         last_display_q       <= last_display_d;
         display_busy_q       <= display_busy_d;
         cpu_read_valid_q     <= cpu_read_valid_d;
         display_read_valid_q <= display_read_valid_d;
         display_read_index_q <= display_read_index_d;
         display_done_q       <= display_done_d;
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: RAM model, queued CPU driver, transaction-level reference
// model and scoreboard comparing grants, addresses and returned words.
module tb_memory_arbiter;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = 8;

   logic clock;
   logic reset;

   memory_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

   memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int            due;
      logic [BW-1:0] idx;
      logic [DW-1:0] data;
      logic          done;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cop_t;

   exp_t          cpu_q[$];
   exp_t          disp_q[$];
   cop_t          cpu_ops[$];
   logic [DW-1:0] ram [0:65535];
   logic [DW-1:0] ref_w [int];
   bit            ram_ready;
   int            cyc;
   bit            rst_at_edge;
   bit            cpu_granted_s;
   bit            timeout_flag;
   bit            timeout_seen;
   int            n_cmp;
   int            n_bad;

   // Model state: burst words still to issue, busy flag, pending drain cycle, last owner.
   logic [AW-1:0] m_base;
   int            m_len;
   int            m_left;
   bit            m_busy;
   bit            m_drain;
   bit            m_last_disp;

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_w.exists(int'(a))) return ref_w[int'(a)];
      return init_word(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Single-port RAM, read data one cycle after the address.
   always @(posedge clock) begin
      if (!ram_ready) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_word(AW'(i));
         ram_ready <= 1'b1;
      end else if (bus.memory_write_enable) begin
         ram[bus.memory_address] <= bus.memory_write_data;
      end
      bus.memory_read_data <= ram[bus.memory_address];
   end

   always @(posedge clock) begin
      cyc         <= cyc + 1;
      rst_at_edge <= reset;
   end

   // CPU driver: holds each queued access until it is granted.
   initial begin
      cop_t op;
      bus.cpu_request      = 1'b0;
      bus.cpu_write_enable = 1'b0;
      bus.cpu_address      = '0;
      bus.cpu_write_data   = '0;
      forever begin
         @(posedge clock);
         #1;
         if (!bus.cpu_request || cpu_granted_s) begin
            if (cpu_ops.size() > 0) begin
               op = cpu_ops.pop_front();
               bus.cpu_request      = 1'b1;
               bus.cpu_write_enable = op.we;
               bus.cpu_address      = op.a;
               bus.cpu_write_data   = op.d;
            end else begin
               bus.cpu_request = 1'b0;
            end
         end
      end
   end

   // Monitor and reference model, evaluated mid-cycle.
   initial begin
      exp_t          e;
      bit            g_cpu, g_d, d_el, accept;
      logic [AW-1:0] exp_addr;
      int            idx;
      forever begin
         @(negedge clock);
         cpu_granted_s = bus.cpu_grant;
         if (cyc == 0) continue;

         if (timeout_flag && !timeout_seen) begin
            timeout_seen = 1'b1;
            check("drain_timeout", 32'(timeout_flag), 0);
         end

         if (!rst_at_edge) begin
            check("reset_busy", bus.display_busy, 0);
            check("reset_cpu_valid", bus.cpu_read_valid, 0);
            check("reset_disp_valid", bus.display_read_valid, 0);
            check("reset_done", bus.display_done, 0);
            check("reset_index", bus.display_read_index, 0);
         end

         if (bus.cpu_read_valid === 1'b1) begin
            if (cpu_q.size() == 0) begin
               check("cpu_spurious_valid", bus.cpu_read_valid, 0);
            end else begin
               e = cpu_q.pop_front();
               check("cpu_valid_cycle", cyc, e.due);
               check("cpu_read_data", bus.cpu_read_data, e.data);
            end
         end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            e = cpu_q.pop_front();
            check("cpu_missing_valid", bus.cpu_read_valid, 1);
         end

         if (bus.display_read_valid === 1'b1) begin
            if (disp_q.size() == 0) begin
               check("disp_spurious_valid", bus.display_read_valid, 0);
            end else begin
               e = disp_q.pop_front();
               check("disp_valid_cycle", cyc, e.due);
               check("disp_index", bus.display_read_index, e.idx);
               check("disp_data", bus.display_read_data, e.data);
               check("disp_done", bus.display_done, e.done);
            end
         end else begin
            if (bus.display_done !== 1'b0) check("done_without_valid", bus.display_done, 0);
            if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
               e = disp_q.pop_front();
               check("disp_missing_valid", bus.display_read_valid, 1);
            end
         end

         check("display_busy", bus.display_busy, m_busy);
         d_el     = (m_left > 0);
         g_cpu    = bus.cpu_request && (!d_el || m_last_disp);
         g_d      = d_el && !g_cpu;
         exp_addr = g_cpu ? bus.cpu_address : m_base + AW'(m_len - m_left);
         check("cpu_grant", bus.cpu_grant, g_cpu);
         check("mem_write_enable", bus.memory_write_enable, g_cpu && bus.cpu_write_enable);
         if (g_cpu) check("cpu_mem_address", bus.memory_address, exp_addr);
         if (g_d) check("disp_mem_address", bus.memory_address, exp_addr);
         if (g_cpu && bus.cpu_write_enable) begin
            check("mem_write_data", bus.memory_write_data, bus.cpu_write_data);
            ref_w[int'(bus.cpu_address)] = bus.cpu_write_data;
         end

         if (!reset) begin
            m_left      = 0;
            m_busy      = 1'b0;
            m_drain     = 1'b0;
            m_last_disp = 1'b1;
         end else begin
            accept = !m_busy && bus.display_request && (bus.display_burst_length != 0);
            if (m_drain) begin
               m_drain = 1'b0;
               m_busy  = 1'b0;
            end
            if (g_cpu) begin
               if (!bus.cpu_write_enable) begin
                  e.due  = cyc + 1;
                  e.idx  = '0;
                  e.data = ref_read(bus.cpu_address);
                  e.done = 1'b0;
                  cpu_q.push_back(e);
               end
               m_last_disp = 1'b0;
            end
            if (g_d) begin
               idx    = m_len - m_left;
               e.due  = cyc + 1;
               e.idx  = BW'(idx);
               e.data = ref_read(exp_addr);
               e.done = (m_left == 1);
               disp_q.push_back(e);
               m_left--;
               m_last_disp = 1'b1;
               if (m_left == 0) m_drain = 1'b1;
            end
            if (accept) begin
               m_base = bus.display_base_address;
               m_len  = int'(bus.display_burst_length);
               m_left = m_len;
               m_busy = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start_burst(input logic [AW-1:0] a, input logic [BW-1:0] l);
      bus.display_request      = 1'b1;
      bus.display_base_address = a;
      bus.display_burst_length = l;
      step();
      bus.display_request = 1'b0;
   endtask

   task automatic push_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cop_t op;
      op.we = we;
      op.a  = a;
      op.d  = d;
      cpu_ops.push_back(op);
   endtask

   initial begin
      int w;
      reset                    = 1'b0;
      bus.display_request      = 1'b0;
      bus.display_base_address = '0;
      bus.display_burst_length = '0;
      repeat (3) step();
      reset = 1'b1;

      push_op(1'b0, 16'h0010, '0);
      repeat (4) step();

      start_burst(16'h0100, 8'd4);
      repeat (8) step();

      for (int i = 0; i < 3; i++) push_op(1'b1, 16'h0200 + AW'(i), DW'($urandom));
      for (int i = 0; i < 3; i++) push_op(1'b0, 16'h0200 + AW'(i), '0);
      start_burst(16'h0300, 8'd3);
      repeat (12) step();

      start_burst(16'hFFFE, 8'd4);
      repeat (7) step();

      start_burst(16'h0040, 8'd0);
      step();
      start_burst(16'h0080, 8'd5);
      step();
      start_burst(16'h0500, 8'd3);
      repeat (8) step();

      // Reset lands on the third issue of a five-word burst.
      start_burst(16'h0600, 8'd5);
      repeat (2) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (2) step();
      start_burst(16'h0700, 8'd5);
      repeat (8) step();

      for (int i = 0; i < 600; i++) begin
         if (cpu_ops.size() < 2 && $urandom_range(0, 2) == 0) begin
            push_op($urandom_range(0, 2) == 0,
                    ($urandom_range(0, 1) == 0) ? 16'h0200 + AW'($urandom_range(0, 31))
                                                : AW'($urandom),
                    DW'($urandom));
         end
         if ($urandom_range(0, 9) == 0) begin
            start_burst(AW'($urandom), BW'($urandom_range(0, 12)));
         end else if ($urandom_range(0, 149) == 0) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end else begin
            step();
         end
      end

      w = 0;
      while ((cpu_ops.size() > 0 || bus.cpu_request || m_busy) && w < 300) begin
         step();
         w++;
      end
      if (w >= 300) timeout_flag = 1'b1;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
